// File: rtl/alu_pkg.sv
// Shared encodings for the iterative ALU: operation codes and FSM state codes.
package alu_pkg;

  localparam logic [2:0] OP_SRA = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/iter_alu_core.sv
// One iteration of the shift / shift-add datapath (combinational).
// The multiply step exists only when ALU_MUL_EN is defined.
module iter_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef ALU_MUL_EN
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] acc_o,
`endif
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

`ifdef ALU_MUL_EN
  logic [WIDTH:0] sum;
`endif

  always_comb begin
    a_o = a_i;
    b_o = b_i;
`ifdef ALU_MUL_EN
    acc_o = acc_i;
    sum   = '0;
`endif
    case (op_i)
      OP_SRA: a_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
      OP_SRL: a_o = {1'b0, a_i[WIDTH-1:1]};
      OP_SLL: a_o = {a_i[WIDTH-2:0], 1'b0};
`ifdef ALU_MUL_EN
      // {acc,b} is the product register; multiplier bits retire out of b's LSB
      OP_MUL: begin
        sum   = {1'b0, acc_i} + (b_i[0] ? {1'b0, a_i} : '0);
        acc_o = sum[WIDTH:1];
        b_o   = {sum[0], b_i[WIDTH-1:1]};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU with valid/ready handshakes; FSM, iteration counter and result registers.
// Optional iterative unsigned multiply enabled by defining ALU_MUL_EN.
//
// state   | meaning
// ST_IDLE | ready for a new operand bundle
// ST_BUSY | iterating, one shift / shift-add step per cycle
// ST_DONE | result held on the outputs until out_ready
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   in_c,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ans_q, ans_d, ans_hi_q, ans_hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic [WIDTH-1:0] core_a, core_b;
  logic [WIDTH:0]   add_w, sub_w;
  logic             mul_sel, iterative;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d, core_acc;
`endif

  iter_alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
`ifdef ALU_MUL_EN
    .acc_i (acc_q),
    .acc_o (core_acc),
`endif
    .a_o   (core_a),
    .b_o   (core_b)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign ans       = ans_q;
  assign ans_hi    = ans_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

  always_comb begin
    add_w = {1'b0, in_a} + {1'b0, in_b};
    sub_w = {1'b0, in_a} - {1'b0, in_b};
`ifdef ALU_MUL_EN
    mul_sel = (op == OP_MUL);
`else
    mul_sel = 1'b0;
`endif
    iterative = mul_sel || (is_shift(op) && (in_c != '0));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    ans_d    = ans_q;
    ans_hi_d = ans_hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op;
          a_d  = in_a;
          b_d  = in_b;
`ifdef ALU_MUL_EN
          acc_d = '0;
`endif
          if (iterative) begin
            state_d = ST_BUSY;
            cnt_d   = mul_sel ? CW'(WIDTH) : CW'(in_c);
          end else begin
            state_d  = ST_DONE;
            ans_hi_d = '0;
            carry_d  = 1'b0;
            err_d    = 1'b0;
            case (op)
              OP_ADD: begin
                ans_d   = add_w[WIDTH-1:0];
                carry_d = add_w[WIDTH];
              end
              OP_SUB: begin
                ans_d   = sub_w[WIDTH-1:0];
                carry_d = sub_w[WIDTH];
              end
              OP_SRA, OP_SRL, OP_SLL: ans_d = in_a;
              default: begin
                ans_d = '0;
                err_d = 1'b1;
              end
            endcase
            zero_d = ~|ans_d;
          end
        end
      end
      ST_BUSY: begin
        a_d   = core_a;
        b_d   = core_b;
        cnt_d = cnt_q - CW'(1);
`ifdef ALU_MUL_EN
        acc_d = core_acc;
`endif
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          ans_d    = core_a;
          ans_hi_d = '0;
          carry_d  = 1'b0;
          err_d    = 1'b0;
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) begin
            ans_d    = core_b;
            ans_hi_d = core_acc;
          end
`endif
          zero_d = ~|{ans_hi_d, ans_d};
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      ans_q    <= '0;
      ans_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      ans_q    <= ans_d;
      ans_hi_q <= ans_hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=8); expectations follow ALU_MUL_EN.
module tb_iter_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, ans, ans_hi;
  logic [2:0] in_c, op;
  logic       carry, zero, err;

  int checks = 0;
  int errors = 0;

  iter_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .ans(ans), .ans_hi(ans_hi), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: results straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] o, input logic [7:0] a, b, input logic [2:0] c,
                                output logic [7:0] r, rh, output logic cy, z, e, output int lat);
    logic [8:0]  w;
    logic [15:0] p;
    r = 0; rh = 0; cy = 0; e = 0; lat = 1;
    case (o)
      3'd0: begin r = $signed(a) >>> c; lat = 1 + int'(c); end
      3'd1: begin r = a >> c;           lat = 1 + int'(c); end
      3'd4: begin r = a << c;           lat = 1 + int'(c); end
      3'd2: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; cy = (a < b); end
      3'd3: begin w = a + b; r = w[7:0]; cy = w[8]; end
`ifdef ALU_MUL_EN
      3'd5: begin p = a * b; r = p[7:0]; rh = p[15:8]; lat = 9; end
`endif
      default: e = 1;
    endcase
    z = ({rh, r} == 16'd0);
  endfunction

  // Issue one bundle, measure latency (1 = valid right after the accept edge), then retire it.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, b, input logic [2:0] c,
                        output logic [7:0] r, rh, output logic cy, z, e, output int lat);
    int n;
    in_valid = 1; op = o; in_a = a; in_b = b; in_c = c; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); in_c = 3'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    lat = out_valid ? n : -1;
    r = ans; rh = ans_hi; cy = carry; z = zero; e = err;
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; in_a = 0; in_b = 0; in_c = 0; op = 0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, ans, ans_hi, carry, zero, err} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b ans=%h hi=%h c=%b z=%b e=%b, expected rdy=1 others 0",
               in_ready, out_valid, ans, ans_hi, carry, zero, err);
    end
    rst_n = 1;
  endtask

  task automatic test_shifts();
    logic [7:0] r, rh; logic cy, z, e; int lat;
    run_op(3'd0, 8'hF0, 8'h00, 3'd2, r, rh, cy, z, e, lat);
    checks++;
    if ({r, e, lat} !== {8'hFC, 1'b0, 32'd3}) begin
      errors++; $display("FAIL sra: ans=%h err=%b lat=%0d, expected FC 0 3", r, e, lat);
    end
    run_op(3'd1, 8'hF0, 8'h00, 3'd2, r, rh, cy, z, e, lat);
    checks++;
    if ({r, e, lat} !== {8'h3C, 1'b0, 32'd3}) begin
      errors++; $display("FAIL srl: ans=%h err=%b lat=%0d, expected 3C 0 3", r, e, lat);
    end
    run_op(3'd0, 8'h85, 8'h00, 3'd0, r, rh, cy, z, e, lat);
    checks++;
    if ({r, lat} !== {8'h85, 32'd1}) begin
      errors++; $display("FAIL sra0: ans=%h lat=%0d, expected 85 1", r, lat);
    end
    run_op(3'd0, 8'h80, 8'h00, 3'd7, r, rh, cy, z, e, lat);
    checks++;
    if ({r, z, lat} !== {8'hFF, 1'b0, 32'd8}) begin
      errors++; $display("FAIL sra7: ans=%h z=%b lat=%0d, expected FF 0 8", r, z, lat);
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] r, rh; logic cy, z, e; int lat;
    run_op(3'd3, 8'hFF, 8'h01, 3'd5, r, rh, cy, z, e, lat);
    checks++;
    if ({r, cy, z, e, lat} !== {8'h00, 1'b1, 1'b1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL add: ans=%h c=%b z=%b e=%b lat=%0d, expected 00 1 1 0 1", r, cy, z, e, lat);
    end
    run_op(3'd2, 8'd3, 8'd5, 3'd0, r, rh, cy, z, e, lat);
    checks++;
    if ({r, cy, z, e, lat} !== {8'hFE, 1'b1, 1'b0, 1'b0, 32'd1}) begin
      errors++; $display("FAIL sub: ans=%h c=%b z=%b e=%b lat=%0d, expected FE 1 0 0 1", r, cy, z, e, lat);
    end
  endtask

  task automatic test_mul();
    logic [7:0] r, rh; logic cy, z, e; int lat;
    run_op(3'd5, 8'd200, 8'd200, 3'd0, r, rh, cy, z, e, lat);
    checks++;
`ifdef ALU_MUL_EN
    if ({rh, r, e, z, lat} !== {8'h9C, 8'h40, 1'b0, 1'b0, 32'd9}) begin
      errors++; $display("FAIL mul200: hi=%h ans=%h e=%b z=%b lat=%0d, expected 9C 40 0 0 9", rh, r, e, z, lat);
    end
    run_op(3'd5, 8'd13, 8'd11, 3'd0, r, rh, cy, z, e, lat);
    checks++;
    if ({rh, r, e} !== {8'h00, 8'h8F, 1'b0}) begin
      errors++; $display("FAIL mul13: hi=%h ans=%h e=%b, expected 00 8F 0", rh, r, e);
    end
`else
    if ({rh, r, e, lat} !== {8'h00, 8'h00, 1'b1, 32'd1}) begin
      errors++; $display("FAIL mul_off: hi=%h ans=%h e=%b lat=%0d, expected 00 00 1 1", rh, r, e, lat);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [7:0] r, rh; logic cy, z, e; int lat;
    run_op(3'd7, 8'h5A, 8'hA5, 3'd3, r, rh, cy, z, e, lat);
    checks++;
    if ({r, rh, cy, z, e, lat} !== {16'h0, 1'b0, 1'b1, 1'b1, 32'd1}) begin
      errors++; $display("FAIL illegal: ans=%h hi=%h c=%b z=%b e=%b lat=%0d, expected 00 00 0 1 1 1",
                         r, rh, cy, z, e, lat);
    end
    run_op(3'd4, 8'h81, 8'h00, 3'd1, r, rh, cy, z, e, lat);
    checks++;
    if ({r, z, e, lat} !== {8'h02, 1'b0, 1'b0, 32'd2}) begin
      errors++; $display("FAIL sll_after_illegal: ans=%h z=%b e=%b lat=%0d, expected 02 0 0 2", r, z, e, lat);
    end
  endtask

  task automatic test_back_pressure();
    in_valid = 1; op = 3'd3; in_a = 8'h12; in_b = 8'h34; in_c = 0; out_ready = 0;
    @(posedge clk); #1;
    op = 3'd2; in_a = 8'h09; in_b = 8'h04;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, ans, carry, zero, err} !== {1'b1, 1'b0, 8'h46, 3'b000}) begin
        errors++; $display("FAIL hold[%0d]: vld=%b rdy=%b ans=%h c=%b z=%b e=%b, expected 1 0 46 0 0 0",
                           i, out_valid, in_ready, ans, carry, zero, err);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if ({out_valid, in_ready, ans} !== {1'b0, 1'b1, 8'h46}) begin
      errors++; $display("FAIL release: vld=%b rdy=%b ans=%h, expected 0 1 46", out_valid, in_ready, ans);
    end
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if ({out_valid, ans, carry, err} !== {1'b1, 8'h05, 1'b0, 1'b0}) begin
      errors++; $display("FAIL next_accept: vld=%b ans=%h c=%b e=%b, expected 1 05 0 0", out_valid, ans, carry, err);
    end
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] r, rh; logic cy, z, e; int lat; bit seen;
    run_op(3'd3, 8'd1, 8'd2, 3'd0, r, rh, cy, z, e, lat);
`ifdef ALU_MUL_EN
    in_valid = 1; op = 3'd5; in_a = 8'hC8; in_b = 8'hC8; in_c = 0;
`else
    in_valid = 1; op = 3'd4; in_a = 8'h0F; in_b = 8'h00; in_c = 3'd7;
`endif
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, ans} !== {1'b0, 1'b0, 8'h03}) begin
      errors++; $display("FAIL busy_hold: vld=%b rdy=%b ans=%h, expected 0 0 03", out_valid, in_ready, ans);
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if ({out_valid, ans, ans_hi, in_ready, err} !== {1'b0, 16'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_reset: vld=%b ans=%h hi=%h rdy=%b e=%b, expected 0 00 00 1 0",
                         out_valid, ans, ans_hi, in_ready, err);
    end
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL aborted_result: out_valid seen=%b, expected 0", seen);
    end
    run_op(3'd3, 8'h70, 8'h25, 3'd0, r, rh, cy, z, e, lat);
    checks++;
    if ({r, cy, e, lat} !== {8'h95, 1'b0, 1'b0, 32'd1}) begin
      errors++; $display("FAIL add_after_reset: ans=%h c=%b e=%b lat=%0d, expected 95 0 0 1", r, cy, e, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] r, rh, er, erh, a, b; logic cy, z, e, ecy, ez, ee; logic [2:0] o, c; int lat, elat;
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom); a = 8'($urandom); b = 8'($urandom); c = 3'($urandom);
      if (i % 8 == 0) c = 0;
      model(o, a, b, c, er, erh, ecy, ez, ee, elat);
      run_op(o, a, b, c, r, rh, cy, z, e, lat);
      checks++;
      if ({r, rh, cy, z, e} !== {er, erh, ecy, ez, ee} || lat != elat) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h c=%0d: got ans=%h hi=%h c=%b z=%b e=%b lat=%0d, expected %h %h %b %b %b %0d",
                 i, o, a, b, c, r, rh, cy, z, e, lat, er, erh, ecy, ez, ee, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, rh; logic cy, z, e; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(3'd3, 8'(i * 16), 8'(i), 3'd0, r, rh, cy, z, e, lat);
      checks++;
      if ({in_ready, out_valid, r} !== {1'b1, 1'b0, 8'(i * 17)}) begin
        errors++; $display("FAIL b2b[%0d]: rdy=%b vld=%b ans=%h, expected 1 0 %h",
                           i, in_ready, out_valid, r, 8'(i * 17));
      end
    end
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_add_sub();
    test_mul();
    test_illegal();
    test_back_pressure();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
